// File: rtl/apb_cmd_initiator.sv
// APB3 initiator: converts single valid/ready commands into APB SETUP/ACCESS
// transfers and reports read data, slave error and timeout on a response port.
module apb_cmd_initiator #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  PCLK,
   input  logic                  PRESETN,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t state, state_next;

   logic [CNT_W-1:0]      wait_cnt, wait_cnt_next;
   logic                  psel_next, penable_next, pwrite_next;
   logic [ADDR_WIDTH-1:0] paddr_next;
   logic [DATA_WIDTH-1:0] pwdata_next;
   logic                  rsp_valid_next, rsp_err_next, rsp_timeout_next;
   logic [DATA_WIDTH-1:0] rsp_rdata_next;
   logic                  timed_out;

   assign cmd_ready = (state == IDLE);
   assign timed_out = (wait_cnt == CNT_LAST);

   always_ff @(posedge PCLK) begin
      if (!PRESETN) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (cmd_valid) state_next = SETUP;
         SETUP:   state_next = ACCESS;
         ACCESS:  if (PREADY || timed_out) state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // PREADY is tested before the timeout so a late slave still wins on the last cycle.
   always_comb begin
      wait_cnt_next    = wait_cnt;
      pwrite_next      = PWRITE;
      paddr_next       = PADDR;
      pwdata_next      = PWDATA;
      rsp_valid_next   = rsp_valid;
      rsp_rdata_next   = rsp_rdata;
      rsp_err_next     = rsp_err;
      rsp_timeout_next = rsp_timeout;
      psel_next        = (state_next == SETUP) || (state_next == ACCESS);
      penable_next     = (state_next == ACCESS);
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               pwrite_next   = cmd_write;
               paddr_next    = cmd_addr;
               pwdata_next   = cmd_wdata;
               wait_cnt_next = '0;
            end
         end
         ACCESS: begin
            if (PREADY) begin
               rsp_valid_next   = 1'b1;
               rsp_rdata_next   = PWRITE ? '0 : PRDATA;
               rsp_err_next     = PSLVERR;
               rsp_timeout_next = 1'b0;
            end else begin
               wait_cnt_next = wait_cnt + CNT_W'(1);
               if (timed_out) begin
                  rsp_valid_next   = 1'b1;
                  rsp_rdata_next   = '0;
                  rsp_err_next     = 1'b1;
                  rsp_timeout_next = 1'b1;
               end
            end
         end
         RESP: begin
            if (rsp_ready) rsp_valid_next = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETN) begin
         wait_cnt    <= '0;
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
         PWRITE      <= 1'b0;
         PADDR       <= '0;
         PWDATA      <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         wait_cnt    <= wait_cnt_next;
         PSEL        <= psel_next;
         PENABLE     <= penable_next;
         PWRITE      <= pwrite_next;
         PADDR       <= paddr_next;
         PWDATA      <= pwdata_next;
         rsp_valid   <= rsp_valid_next;
         rsp_rdata   <= rsp_rdata_next;
         rsp_err     <= rsp_err_next;
         rsp_timeout <= rsp_timeout_next;
      end
   end

endmodule

// File: tb/tb_apb_cmd_initiator.sv
// Self-checking bench for apb_cmd_initiator: behavioural APB slave plus a
// response scoreboard filled as commands are issued.
module tb_apb_cmd_initiator;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic        tmo;
   } rsp_t;

   logic        PCLK = 1'b0;
   logic        PRESETN;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [7:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        PSEL, PENABLE, PWRITE;
   logic [7:0]  PADDR;
   logic [31:0] PWDATA, PRDATA;
   logic        PREADY, PSLVERR;

   rsp_t sb[$];
   int   n_cmp = 0;
   int   n_fail = 0;

   // slave behaviour knobs
   int          slv_wait = 0;
   logic        slv_stuck = 1'b0;
   logic        slv_err = 1'b0;
   logic [31:0] slv_rdata = '0;

   // monitor state
   int          acc_seen = 0;
   int          psel_cnt = 0;
   int          pen_cnt = 0;
   int          bad_enable = 0;
   int          unstable_addr = 0;
   logic        cap_write;
   logic [7:0]  cap_addr;
   logic [31:0] cap_wdata;

   apb_cmd_initiator #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
      .PCLK(PCLK), .PRESETN(PRESETN),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   // Slave answers after slv_wait stalled ACCESS cycles; monitor tracks the bus.
   always @(negedge PCLK) begin
      if (PSEL && PENABLE) acc_seen = acc_seen + 1;
      else acc_seen = 0;
      PREADY  = PSEL && PENABLE && !slv_stuck && (acc_seen > slv_wait);
      PRDATA  = slv_rdata;
      PSLVERR = slv_err && PREADY;
      if (PSEL) psel_cnt = psel_cnt + 1;
      if (PENABLE) pen_cnt = pen_cnt + 1;
      if (PENABLE && !PSEL) bad_enable = bad_enable + 1;
      if (PSEL && !PENABLE) begin
         cap_write = PWRITE;
         cap_addr  = PADDR;
         cap_wdata = PWDATA;
      end
      if (PSEL && PENABLE && (PADDR !== cap_addr || PWDATA !== cap_wdata || PWRITE !== cap_write))
         unstable_addr = unstable_addr + 1;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d);
      bit accepted = 0;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      psel_cnt  = 0;
      pen_cnt   = 0;
      for (int i = 0; i < 50 && !accepted; i++) begin
         if (cmd_ready === 1'b1) begin
            accepted = 1;
            @(posedge PCLK);
         end
         @(negedge PCLK);
      end
      cmd_valid = 1'b0;
      n_cmp++;
      if (!accepted) begin
         n_fail++;
         $display("[TB] FAIL accept: command addr %h not accepted, got 0 required 1", a);
      end
   endtask

   task automatic wait_rsp(output int lat);
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 100) begin
         @(negedge PCLK);
         lat++;
      end
   endtask

   task automatic take_rsp(input int hold);
      rsp_t exp, snap;
      int   unstable = 0;
      if (sb.size() == 0) begin
         exp = '0;
         n_cmp++;
         n_fail++;
         $display("[TB] FAIL scoreboard: response with empty queue, got 1 required 0");
      end else begin
         exp = sb.pop_front();
      end
      n_cmp++;
      if (rsp_valid !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL rsp_valid: got %b required 1", rsp_valid);
      end
      n_cmp++;
      if (rsp_rdata !== exp.rdata) begin
         n_fail++;
         $display("[TB] FAIL rsp_rdata: got %h required %h", rsp_rdata, exp.rdata);
      end
      n_cmp++;
      if ({rsp_err, rsp_timeout} !== {exp.err, exp.tmo}) begin
         n_fail++;
         $display("[TB] FAIL rsp_err/timeout: got %b%b required %b%b",
                  rsp_err, rsp_timeout, exp.err, exp.tmo);
      end
      snap = '{rsp_rdata, rsp_err, rsp_timeout};
      rsp_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(negedge PCLK);
         if (rsp_valid !== 1'b1 || {rsp_rdata, rsp_err, rsp_timeout} !== snap
             || cmd_ready !== 1'b0 || PSEL !== 1'b0)
            unstable++;
      end
      if (hold > 0) begin
         n_cmp++;
         if (unstable != 0) begin
            n_fail++;
            $display("[TB] FAIL backpressure: %0d unstable cycles, required 0", unstable);
         end
      end
      rsp_ready = 1'b1;
      @(posedge PCLK);
      @(negedge PCLK);
      rsp_ready = 1'b0;
      n_cmp++;
      if ({rsp_valid, cmd_ready} !== 2'b01) begin
         n_fail++;
         $display("[TB] FAIL handshake: rsp_valid,cmd_ready got %b%b required 01",
                  rsp_valid, cmd_ready);
      end
   endtask

   task automatic test_reset();
      PRESETN = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge PCLK);
      n_cmp++;
      if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout} !== 6'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_ctrl: got %b required 000000",
                  {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout});
      end
      n_cmp++;
      if ({PADDR, PWDATA, rsp_rdata} !== 72'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_data: got %h %h %h required 0", PADDR, PWDATA, rsp_rdata);
      end
      PRESETN = 1'b1;
      @(negedge PCLK);
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL reset_cmd_ready: got %b required 1", cmd_ready);
      end
   endtask

   task automatic test_write_zero_wait();
      int lat;
      slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'h1234_5678;
      sb.push_back('{32'h0, 1'b0, 1'b0});
      issue(1'b1, 8'h08, 32'h0000_0003);
      wait_rsp(lat);
      n_cmp++;
      if (lat != 3) begin
         n_fail++;
         $display("[TB] FAIL write_latency: got %0d required 3", lat);
      end
      n_cmp++;
      if (psel_cnt != 2 || pen_cnt != 1) begin
         n_fail++;
         $display("[TB] FAIL write_cycles: psel/penable got %0d/%0d required 2/1", psel_cnt, pen_cnt);
      end
      n_cmp++;
      if ({cap_write, cap_addr, cap_wdata} !== {1'b1, 8'h08, 32'h3}) begin
         n_fail++;
         $display("[TB] FAIL write_bus: got %b %h %h required 1 08 00000003",
                  cap_write, cap_addr, cap_wdata);
      end
      take_rsp(0);
   endtask

   task automatic test_read_wait3();
      int lat;
      slv_wait = 3; slv_err = 1'b0; slv_rdata = 32'h0000_0002;
      sb.push_back('{32'h2, 1'b0, 1'b0});
      issue(1'b0, 8'h40, 32'hFFFF_FFFF);
      wait_rsp(lat);
      n_cmp++;
      if (lat != 6) begin
         n_fail++;
         $display("[TB] FAIL read_latency: got %0d required 6", lat);
      end
      n_cmp++;
      if (pen_cnt != 4 || psel_cnt != 5) begin
         n_fail++;
         $display("[TB] FAIL read_cycles: penable/psel got %0d/%0d required 4/5", pen_cnt, psel_cnt);
      end
      n_cmp++;
      if ({cap_write, cap_addr} !== {1'b0, 8'h40}) begin
         n_fail++;
         $display("[TB] FAIL read_bus: got %b %h required 0 40", cap_write, cap_addr);
      end
      take_rsp(0);
      slv_wait = 0;
   endtask

   task automatic test_slave_error();
      int lat;
      slv_err = 1'b1; slv_rdata = 32'hDEAD_BEEF;
      sb.push_back('{32'hDEAD_BEEF, 1'b1, 1'b0});
      issue(1'b0, 8'h80, 32'h0);
      wait_rsp(lat);
      take_rsp(0);
      slv_err = 1'b0;
   endtask

   task automatic test_timeout();
      int lat;
      slv_stuck = 1'b1; slv_rdata = 32'hCAFE_F00D;
      sb.push_back('{32'h0, 1'b1, 1'b1});
      issue(1'b0, 8'h10, 32'h0);
      wait_rsp(lat);
      n_cmp++;
      if (pen_cnt != 4) begin
         n_fail++;
         $display("[TB] FAIL timeout_access: got %0d ACCESS cycles required 4", pen_cnt);
      end
      n_cmp++;
      if ({PSEL, PENABLE} !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL timeout_bus: psel,penable got %b%b required 00", PSEL, PENABLE);
      end
      take_rsp(0);
      slv_stuck = 1'b0;
   endtask

   task automatic test_back_to_back();
      int lat;
      slv_wait = 0; slv_rdata = 32'h0000_0055;
      sb.push_back('{32'h0, 1'b0, 1'b0});
      sb.push_back('{32'h55, 1'b0, 1'b0});
      issue(1'b1, 8'h20, 32'h0000_00A5);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h24; cmd_wdata = 32'h0;
      wait_rsp(lat);
      take_rsp(5);
      @(negedge PCLK);
      cmd_valid = 1'b0;
      psel_cnt = 0; pen_cnt = 0;
      n_cmp++;
      if ({PSEL, PENABLE, PWRITE, PADDR} !== {3'b100, 8'h24}) begin
         n_fail++;
         $display("[TB] FAIL second_cmd: psel,penable,pwrite,paddr got %b%b%b %h required 100 24",
                  PSEL, PENABLE, PWRITE, PADDR);
      end
      wait_rsp(lat);
      take_rsp(0);
   endtask

   task automatic test_reset_mid_access();
      int seen = 0;
      slv_stuck = 1'b1;
      issue(1'b0, 8'h30, 32'h0);
      @(negedge PCLK);
      n_cmp++;
      if (PENABLE !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL mid_access_enter: penable got %b required 1", PENABLE);
      end
      PRESETN = 1'b0;
      @(negedge PCLK);
      n_cmp++;
      if ({PSEL, PENABLE, rsp_valid} !== 3'b000) begin
         n_fail++;
         $display("[TB] FAIL mid_reset_bus: got %b required 000", {PSEL, PENABLE, rsp_valid});
      end
      PRESETN = 1'b1;
      @(negedge PCLK);
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL mid_reset_ready: got %b required 1", cmd_ready);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge PCLK);
         if (rsp_valid !== 1'b0 || PSEL !== 1'b0) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
         n_fail++;
         $display("[TB] FAIL mid_reset_quiet: got %0d active cycles required 0", seen);
      end
      slv_stuck = 1'b0;
   endtask

   task automatic test_protocol();
      n_cmp++;
      if (bad_enable != 0) begin
         n_fail++;
         $display("[TB] FAIL penable_without_psel: got %0d required 0", bad_enable);
      end
      n_cmp++;
      if (unstable_addr != 0) begin
         n_fail++;
         $display("[TB] FAIL bus_stability: got %0d required 0", unstable_addr);
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL scoreboard_drain: got %0d left required 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_write_zero_wait();
      test_read_wait3();
      test_slave_error();
      test_timeout();
      test_back_to_back();
      test_reset_mid_access();
      test_protocol();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_cmd_initiator.md
Name: apb_cmd_initiator

Overview:
- APB3 initiator that turns single read/write commands from a valid/ready command port into APB SETUP/ACCESS transfers.
- Drives peripheral slaves such as the GPIO controller directly from fabric logic, with no processor bus in the path.
- Returns read data, slave error and timeout status on a valid/ready response port.
- Handles one outstanding transfer at a time.

Parameters:
- ADDR_WIDTH, 8, width of PADDR and cmd_addr.
- DATA_WIDTH, 32, width of PWDATA, PRDATA, cmd_wdata and rsp_rdata.
- TIMEOUT, 255, number of ACCESS cycles without PREADY before the transfer is aborted (range 1 to 65535).

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESETN  in  1  reset; synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for timeouts.
- rsp_err  out  1  PSLVERR was sampled, or the transfer timed out.
- rsp_timeout  out  1  transfer aborted by timeout.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Reset (PRESETN low at a PCLK edge):
  - State goes to IDLE.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err and rsp_timeout all go to 0; the wait counter clears.
  - A reset mid-transfer drops the transfer with no response; PSEL/PENABLE are low on the following cycle.
- All outputs are registered, except cmd_ready = (state == IDLE).
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On handshake, latch cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA, then go to SETUP.
- SETUP:
  - PSEL = 1, PENABLE = 0. Lasts exactly one cycle, then ACCESS.
- ACCESS:
  - PSEL = 1, PENABLE = 1. Wait counter increments each cycle PREADY is low.
  - PREADY high: capture PRDATA into rsp_rdata for reads (0 for writes); rsp_err = PSLVERR; rsp_timeout = 0. Drop PSEL/PENABLE, assert rsp_valid, go to RESP.
  - PREADY still low with the counter at TIMEOUT−1: abort. Drop PSEL/PENABLE, rsp_rdata = 0, rsp_err = 1, rsp_timeout = 1, assert rsp_valid, go to RESP.
  - PREADY takes priority over timeout on the same cycle.
  - A zero-wait slave therefore spends exactly one ACCESS cycle.
- RESP:
  - rsp_valid = 1; rsp_* stable until rsp_ready.
  - rsp_valid && rsp_ready: rsp_valid drops, return to IDLE. No new command is accepted in that same cycle; cmd_ready rises the next cycle.
- Latency: command accepted at edge N → SETUP cycle N+1 → ACCESS N+2 → with PREADY=1 at N+2, rsp_valid from N+3.
  - Minimum command-to-command spacing is 4 cycles.
- PADDR, PWDATA and PWRITE are stable from SETUP through ACCESS and hold their last value in IDLE/RESP.
- PENABLE is never high without PSEL. PSEL is never high outside SETUP/ACCESS.
- The counter resets on each entry to SETUP. Its width is ceil(log2(TIMEOUT+1)).
- Inputs on cmd_* while not in IDLE are ignored.

Test Plan:
- Write, zero-wait slave:
  - Stimulus: cmd write addr 0x08, data 0x00000003; slave PREADY=1.
  - Required: PSEL high 2 cycles, PENABLE high 1 cycle, PWRITE=1, PADDR=0x08, PWDATA=0x3; rsp_valid 3 cycles after accept with rsp_err=0 and rsp_rdata=0.
- Read with 3 wait states:
  - Stimulus: cmd read addr 0x40; slave holds PREADY low 3 ACCESS cycles, then PREADY=1 with PRDATA=0x00000002.
  - Required: PENABLE high 4 cycles; rsp_rdata=0x2, rsp_err=0.
- Slave error:
  - Stimulus: read addr 0x80; slave returns PREADY=1, PSLVERR=1, PRDATA=0xDEADBEEF.
  - Required: rsp_err=1, rsp_timeout=0, rsp_rdata=0xDEADBEEF.
- Timeout:
  - Stimulus: TIMEOUT=4; slave PREADY stuck low.
  - Required: exactly 4 ACCESS cycles, then PSEL=PENABLE=0; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Response backpressure:
  - Stimulus: rsp_ready held low 5 cycles while cmd_valid stays high with a second command.
  - Required: rsp_* stable throughout, cmd_ready=0, no PSEL; second command accepted the cycle after the rsp handshake.
- Reset mid-ACCESS:
  - Stimulus: PRESETN low during ACCESS with PREADY=0.
  - Required: next cycle PSEL=PENABLE=rsp_valid=0, cmd_ready=1 once reset is released; no response emitted.
